instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 80 ++++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, one-outstanding imem request, held instruction register for the decoder.
// Define IFU_PERF_CNT_EN to add fetch_count/stall_count performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        instr_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;
    state_t state;
    logic [31:0] pc;
    logic [31:0] target;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign target    = {branch_target[31:2], 2'b00};
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            instruction <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
`ifdef IFU_PERF_CNT_EN
            fetch_count <= '0;
            stall_count <= '0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    // a branch drops any word returned in the same cycle; a ready word outranks halt
                    if (branch_taken) begin
                        pc <= target;
                    end else if (imem_ready) begin
                        instruction <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + PC_STEP;
                        state       <= HOLD;
                    end else if (halt) begin
                        state <= HALTED;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        pc          <= target;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= halt ? HALTED : FETCH;
`ifdef IFU_PERF_CNT_EN
                        fetch_count <= fetch_count + 32'd1;
`endif
                    end else begin
`ifdef IFU_PERF_CNT_EN
                        stall_count <= stall_count + 32'd1;
`endif
                    end
                end
                default: instr_valid <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed-vector bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif
    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
        .instruction(instruction), .pc_out(pc_out),
`ifdef IFU_PERF_CNT_EN
        .fetch_count(fetch_count), .stall_count(stall_count),
`endif
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        reset = 1'b0;
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    endtask

    task automatic test_zero_wait();
        imem_ready = 1'b1;
        imem_rdata = 32'h2001_0005;
        step();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h0 || instruction !== 32'h2001_0005) begin errors++; $display("FAIL zw_first got v=%b pc=%h i=%h exp v=1 pc=0 i=20010005", instr_valid, pc_out, instruction); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_hold_req got %b exp 0", imem_req); end
        imem_rdata = 32'h0022_1820;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++; $display("FAIL zw_fetch2 got req=%b addr=%h v=%b exp req=1 addr=4 v=0", imem_req, imem_addr, instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instruction !== 32'h0022_1820) begin errors++; $display("FAIL zw_second got v=%b pc=%h i=%h exp v=1 pc=4 i=00221820", instr_valid, pc_out, instruction); end
        imem_ready = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_hold%0d got req=%b addr=%h v=%b exp req=1 addr=8 v=0", i, imem_req, imem_addr, instr_valid); end
            if (i == 2) begin
                imem_ready = 1'b1;
                imem_rdata = 32'h1111_2222;
            end
            step();
        end
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h8 || instruction !== 32'h1111_2222) begin errors++; $display("FAIL wait_capture got v=%b pc=%h i=%h exp v=1 pc=8 i=11112222", instr_valid, pc_out, instruction); end
        step();
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL wait_next got req=%b addr=%h exp req=1 addr=c", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        imem_ready = 1'b1;
        imem_rdata = 32'h3333_4444;
        step();
        imem_ready = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (instr_valid !== 1'b1 || pc_out !== 32'hC || instruction !== 32'h3333_4444 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_cyc%0d got v=%b pc=%h i=%h req=%b exp v=1 pc=c i=33334444 req=0", i, instr_valid, pc_out, instruction, imem_req); end
            step();
        end
        stall = 1'b0;
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_release got v=%b req=%b exp v=1 req=0", instr_valid, imem_req); end
        step();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_next got v=%b req=%b addr=%h exp v=0 req=1 addr=10", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_branch_hold();
        imem_ready = 1'b1;
        imem_rdata = 32'h5555_6666;
        step();
        imem_ready = 1'b0;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL br_hold got v=%b req=%b addr=%h exp v=0 req=1 addr=40", instr_valid, imem_req, imem_addr); end
        imem_ready = 1'b1;
        imem_rdata = 32'h7777_8888;
        step();
        imem_ready = 1'b0;
        checks++; if (pc_out !== 32'h40 || instruction !== 32'h7777_8888) begin errors++; $display("FAIL br_target_word got pc=%h i=%h exp pc=40 i=77778888", pc_out, instruction); end
        step();
        checks++; if (imem_addr !== 32'h44 || imem_req !== 1'b1) begin errors++; $display("FAIL br_seq got req=%b addr=%h exp req=1 addr=44", imem_req, imem_addr); end
    endtask

    task automatic test_branch_with_ready();
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0100;
        step();
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL br_ready got v=%b req=%b addr=%h exp v=0 req=1 addr=100", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_mask got %h exp fffffffc", imem_addr); end
        imem_ready = 1'b1;
        imem_rdata = 32'h9999_AAAA;
        step();
        imem_ready = 1'b0;
        checks++; if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc_out got pc=%h v=%b exp pc=fffffffc v=1", pc_out, instr_valid); end
        step();
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_halt_stall();
        imem_ready = 1'b1;
        imem_rdata = 32'hCCCC_DDDD;
        step();
        imem_ready = 1'b0;
        stall = 1'b1;
        halt = 1'b1;
        step();
        step();
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h0) begin errors++; $display("FAIL halt_deferred got v=%b req=%b pc=%h exp v=1 req=0 pc=0", instr_valid, imem_req, pc_out); end
        stall = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter got v=%b req=%b exp v=0 req=0", instr_valid, imem_req); end
        halt = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h4) begin errors++; $display("FAIL halt_frozen got v=%b req=%b addr=%h exp v=0 req=0 addr=4", instr_valid, imem_req, imem_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_out !== 32'h0 || instruction !== 32'h0) begin errors++; $display("FAIL halt_reset got req=%b addr=%h pc=%h i=%h exp req=1 addr=0 pc=0 i=0", imem_req, imem_addr, pc_out, instruction); end
    endtask

    task automatic test_halt_fetch();
        halt = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hEEEE_0001;
        step();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instruction !== 32'hEEEE_0001) begin errors++; $display("FAIL halt_ready_capture got v=%b i=%h exp v=1 i=eeee0001", instr_valid, instruction); end
        step();
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_after_accept got v=%b req=%b exp v=0 req=0", instr_valid, imem_req); end
        halt = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL halt_idle got req=%b v=%b addr=%h exp req=0 v=0 addr=0", imem_req, instr_valid, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch_hold();
        test_branch_with_ready();
        test_wrap();
        test_halt_stall();
        test_halt_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
